// File: rtl/ptp_bus_master.sv
// Point-to-point bus master: turns single writes and read bursts into strobed
// bus accesses with a fixed read latency and a ready/valid response channel.
`timescale 1ns/1ps
module ptp_bus_master #(
  parameter int RD_LAT   = 2,
  parameter int ADDR_INC = 4
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic [31:0] bus2ip_addr_o,
  output logic [31:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic [31:0] ip2bus_data_i,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_RSP  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam logic [3:0]  LAT_LAST  = 4'(RD_LAT - 1);
  localparam logic [31:0] ADDR_STEP = 32'(ADDR_INC);

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s, wdata_r, wdata_s, rdata_r, rdata_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [3:0]  wait_cnt_r, wait_s;
  logic        more_r, more_s;

  // Outputs are registered from the next-state view so they line up with the state
  logic        cmd_ready_r, cmd_ready_s, busy_r, busy_s;
  logic        rd_ce_r, rd_ce_s, wr_ce_r, wr_ce_s;
  logic        rsp_valid_r, rsp_valid_s, rsp_last_r, rsp_last_s;
  logic [31:0] bus_addr_r, bus_addr_s, bus_data_r, bus_data_s;

  // Next-state, burst bookkeeping and read-data capture
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    cnt_s   = cnt_r;
    more_s  = more_r;
    wait_s  = wait_cnt_r;
    rdata_s = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_s = cmd_wr ? ST_WR : ST_RD;
          addr_s  = cmd_addr;
          wdata_s = cmd_wdata;
          cnt_s   = cmd_len;
          more_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: state_s = ST_GAP;
      ST_RD: begin
        state_s = ST_WAIT;
        wait_s  = 4'd0;
      end
      ST_WAIT: begin
        // Slave data is only looked at on the last wait cycle
        if (wait_cnt_r == LAT_LAST) begin
          state_s = ST_RSP;
          rdata_s = ip2bus_data_i;
        end else begin
          wait_s = wait_cnt_r + 4'd1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_s = ST_GAP;
          if (cnt_r != 8'd0) begin
            cnt_s  = cnt_r - 8'd1;
            addr_s = addr_r + ADDR_STEP;
            more_s = 1'b1;
          end else begin
            more_s = 1'b0;
          end
        end else begin
          state_s = ST_RSP;
        end
      end
      ST_GAP:  state_s = more_r ? ST_RD : ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle; addr/data are forced to 0 without a strobe
  always_comb begin
    rd_ce_s     = (state_s == ST_RD);
    wr_ce_s     = (state_s == ST_WR);
    bus_addr_s  = (rd_ce_s || wr_ce_s) ? addr_s : 32'd0;
    bus_data_s  = wr_ce_s ? wdata_s : 32'd0;
    rsp_valid_s = (state_s == ST_RSP);
    rsp_last_s  = rsp_valid_s && (cnt_s == 8'd0);
    busy_s      = (state_s != ST_IDLE);
    cmd_ready_s = (state_s == ST_IDLE);
  end

  // State, datapath and output registers; reset drops everything immediately
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      cnt_r       <= 8'd0;
      wait_cnt_r  <= 4'd0;
      more_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      rd_ce_r     <= 1'b0;
      wr_ce_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_data_r  <= 32'd0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rdata_r     <= rdata_s;
      cnt_r       <= cnt_s;
      wait_cnt_r  <= wait_s;
      more_r      <= more_s;
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
      rd_ce_r     <= rd_ce_s;
      wr_ce_r     <= wr_ce_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_last_r  <= rsp_last_s;
      bus_addr_r  <= bus_addr_s;
      bus_data_r  <= bus_data_s;
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign busy           = busy_r;
  assign bus2ip_rd_ce_o = rd_ce_r;
  assign bus2ip_wr_ce_o = wr_ce_r;
  assign bus2ip_addr_o  = bus_addr_r;
  assign bus2ip_data_o  = bus_data_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_last       = rsp_last_r;
  assign rsp_rdata      = rdata_r;

endmodule

// File: tb/tb_ptp_bus_master.sv
// Scoreboard bench for ptp_bus_master: expected bus accesses and responses are
// queued at issue time and checked by negedge monitors.
`timescale 1ns/1ps
module tb_ptp_bus_master;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        rsp_ready = 1'b0;
  logic [31:0] ip2bus_data_i = 32'hBAD0_BAD0;
  logic        cmd_ready, rsp_valid, rsp_last, rd_ce, wr_ce, busy;
  logic [31:0] rsp_rdata, bus_addr, bus_data;

  ptp_bus_master #(.RD_LAT(RD_LAT), .ADDR_INC(4)) dut (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .bus2ip_addr_o(bus_addr), .bus2ip_data_o(bus_data),
    .bus2ip_rd_ce_o(rd_ce), .bus2ip_wr_ce_o(wr_ce),
    .ip2bus_data_i(ip2bus_data_i), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic last; } rsp_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int n_pass = 0, n_total = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic [31:0] slave_addr;
  logic prev_stall = 1'b0, prev_strobe = 1'b0;
  logic [31:0] prev_data = 32'd0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {26'd0, cmd_ready, busy, rd_ce, wr_ce, rsp_valid, rsp_last}, 32'd0);
    check({name, "_bus"}, bus_addr | bus_data, 32'd0);
    check({name, "_rdata"}, rsp_rdata, 32'd0);
  endtask

  // Slave: valid read data only in the capture cycle, junk everywhere else
  always begin
    @(negedge clk);
    if (rd_ce) begin
      slave_addr = bus_addr;
      repeat (RD_LAT) @(posedge clk);
      #1 ip2bus_data_i = slave_data(slave_addr);
      @(posedge clk);
      #1 ip2bus_data_i = 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitors: response scoreboard, bus scoreboard and strobe protocol
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        automatic rsp_t e = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
    if (prev_stall && rst_n) begin
      check("rsp_stable_valid", 32'(rsp_valid), 32'd1);
      check("rsp_stable_data", rsp_rdata, prev_data);
    end
    if (rd_ce || wr_ce) begin
      if (bus_q.size() == 0) check("bus_unexpected", bus_addr, 32'hFFFF_FFFF);
      else begin
        automatic bus_t b = bus_q.pop_front();
        check("bus_wr", 32'(wr_ce), 32'(b.wr));
        check("bus_addr", bus_addr, b.addr);
        check("bus_data", bus_data, b.data);
      end
    end else begin
      check("idle_addr_data", bus_addr | bus_data, 32'd0);
    end
    check("strobe_both", 32'(rd_ce && wr_ce), 32'd0);
    check("strobe_adjacent", 32'((rd_ce || wr_ce) && prev_strobe), 32'd0);
    check("strobe_during_rsp", 32'(rsp_valid && (rd_ce || wr_ce)), 32'd0);
    prev_stall  <= rst_n && rsp_valid && !rsp_ready;
    prev_data   <= rsp_rdata;
    prev_strobe <= rst_n && (rd_ce || wr_ce);
  end

  // Present a command and return just after the accepting edge (cycle T+1)
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [7:0] len);
    int guard = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_wr = ~wr; cmd_addr = 32'hDEAD_0000; cmd_wdata = 32'hDEAD_BEEF; cmd_len = 8'hFF;
    end
  endtask

  task automatic push_read(input logic [31:0] a, input int len);
    logic [31:0] addr = a;
    for (int i = 0; i <= len; i++) begin
      bus_q.push_back('{wr: 1'b0, addr: addr, data: 32'd0});
      rsp_q.push_back('{data: slave_data(addr), last: (i == len)});
      addr = addr + 32'd4;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(rsp_q.size() + bus_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Single write
    bus_q.push_back('{wr: 1'b1, addr: 32'h0000_0300, data: 32'hA5A5_0001});
    issue(1'b1, 32'h0000_0300, 32'hA5A5_0001, 8'd0);
    @(negedge clk); check("wr_t1", 32'(wr_ce), 32'd1);
    @(negedge clk); check("wr_t2", {30'd0, wr_ce, cmd_ready}, 32'd0);
    @(negedge clk); check("ready_t3", 32'(cmd_ready), 32'd1);

    // Single read latency
    bus_q.push_back('{wr: 1'b0, addr: 32'h0000_1000, data: 32'd0});
    rsp_q.push_back('{data: 32'h1234_5678, last: 1'b1});
    issue(1'b0, 32'h0000_1000, 32'd0, 8'd0);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rd_latency", 32'(k), 32'(2 + RD_LAT));
    wait_drain();

    // Four-beat burst, first beat stalled
    ready_mode = 2;
    push_read(32'h0000_2000, 3);
    issue(1'b0, 32'h0000_2000, 32'd0, 8'd3);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall_reached", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    ready_mode = 0;
    wait_drain();

    // Address wrap
    bus_q.push_back('{wr: 1'b0, addr: 32'hFFFF_FFFC, data: 32'd0});
    bus_q.push_back('{wr: 1'b0, addr: 32'h0000_0000, data: 32'd0});
    rsp_q.push_back('{data: 32'hFFFC_0003, last: 1'b0});
    rsp_q.push_back('{data: 32'h0000_FFFF, last: 1'b1});
    issue(1'b0, 32'hFFFF_FFFC, 32'd0, 8'd1);
    wait_drain();

    // Reset in WAIT of a 4-beat burst
    push_read(32'h0000_4000, 3);
    issue(1'b0, 32'h0000_4000, 32'd0, 8'd3);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_abort", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);

    // Random command stream with random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      automatic logic        wr = 1'($urandom_range(0, 1));
      automatic logic [31:0] a  = $urandom & 32'hFFFF_FFFC;
      automatic logic [31:0] d  = $urandom;
      automatic int          ln = $urandom_range(0, 3);
      if (i == 0) a = 32'hFFFF_FFF8;
      if (wr) bus_q.push_back('{wr: 1'b1, addr: a, data: d});
      else push_read(a, ln);
      issue(wr, a, d, 8'(ln));
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ptp_bus_master.md
PTP_BUS_MASTER -- requirements
Module: ptp_bus_master

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning cycles from the rd_ce cycle to the cycle in which ip2bus_data_i is valid (range 1..15).
REQ-002 SHALL have parameter ADDR_INC, default 4, meaning the byte address increment between read-burst beats.
REQ-003 SHALL have port bus2ip_clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port bus2ip_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, 32 bits: start byte address.
REQ-009 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-010 SHALL have port cmd_len, input, 8 bits: read beats minus 1; ignored for writes.
REQ-011 SHALL have port rsp_valid, output, 1 bit: read data available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: consumer accepts rsp_rdata.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-014 SHALL have port rsp_last, output, 1 bit: final beat of a burst.
REQ-015 SHALL have port bus2ip_addr_o, output, 32 bits: bus address.
REQ-016 SHALL have port bus2ip_data_o, output, 32 bits: bus write data.
REQ-017 SHALL have port bus2ip_rd_ce_o, output, 1 bit: read strobe, active high.
REQ-018 SHALL have port bus2ip_wr_ce_o, output, 1 bit: write strobe, active high.
REQ-019 SHALL have port ip2bus_data_i, input, 32 bits: OR-combined slave read data.
REQ-020 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-021 SHALL implement states IDLE, WR, RD, WAIT, RSP, GAP.
REQ-022 SHALL drive cmd_ready=1 only in IDLE.
REQ-023 On accept in IDLE: cmd_wr=1 -> WR; cmd_wr=0 -> RD; latch addr, wdata and beat count = cmd_len.
REQ-024 In WR (exactly 1 cycle), SHALL drive wr_ce=1, addr=latched addr and data=latched wdata, then go to GAP.
REQ-025 In RD (exactly 1 cycle), SHALL drive rd_ce=1 and addr=current addr, then go to WAIT.
REQ-026 WAIT SHALL last RD_LAT cycles; ip2bus_data_i SHALL be captured into rsp_rdata at the end of the RD_LAT-th cycle after RD; the FSM then goes to RSP.
REQ-027 In RSP, rsp_valid=1 and rsp_rdata stays stable until rsp_ready=1.
REQ-028 On handshake in RSP: if beats remain, decrement the count, add ADDR_INC to addr (modulo 2^32, wraps at 0xFFFFFFFC -> 0x00000000) and go to GAP; otherwise go to GAP with the burst ended.
REQ-029 rsp_last SHALL be 1 in RSP when the remaining count is 0.
REQ-030 GAP (exactly 1 cycle, all strobes 0) SHALL then go to RD if the burst continues, else to IDLE.
REQ-031 Strobes SHALL never be high in consecutive cycles, and rd_ce and wr_ce SHALL never be high together.
REQ-032 bus2ip_addr_o and bus2ip_data_o SHALL be 0 whenever their strobe is 0.
REQ-033 Latency: accept at edge T -> wr_ce/rd_ce high in cycle T+1; first rsp_valid in cycle T+2+RD_LAT.
REQ-034 Back-to-back: cmd_ready reasserts in the cycle after GAP; a write costs 3 cycles including accept.
REQ-035 ip2bus_data_i SHALL be ignored outside the capture cycle.
REQ-036 cmd_* changes while busy SHALL have no effect.

Reset
REQ-037 While bus2ip_rst_n=0, all outputs SHALL be 0, state SHALL be IDLE, and counters and latches SHALL be cleared.
REQ-038 Reset asserted mid-burst SHALL abort immediately with no further strobes, and any pending response SHALL be discarded.
REQ-039 After release, cmd_ready SHALL be 1 on the first clock edge.

Verification
REQ-040 Write 0x300 data 0xA5A5_0001 accepted at T -> wr_ce=1, addr=0x300, data=0xA5A50001 for exactly one cycle T+1; cmd_ready=1 at T+3.
REQ-041 Read 0x1000 len 0, RD_LAT=2, slave returns 0x12345678 in cycle T+3 -> rsp_valid at T+4, rdata=0x12345678, rsp_last=1.
REQ-042 Read 0x2000 len 3 with rsp_ready held low 5 cycles on beat 1 -> addrs 0x2000/04/08/0C, rdata stable while stalled, rsp_last only on beat 4, no strobe during stall.
REQ-043 Read 0xFFFFFFFC len 1 -> second beat addr=0x00000000.
REQ-044 bus2ip_rst_n pulsed low during WAIT of a 4-beat burst -> all outputs 0 at once; no rsp_valid after release; cmd_ready=1.
REQ-045 Random command stream -> strobes never high in adjacent cycles, never both high, and addr/data=0 whenever no strobe is active.
